// File: rtl/branch_resolve.sv
// Branch resolution stage: decodes MIPS-style conditional branches, computes
// target/link/redirect addresses, registers the result behind a one-deep
// valid/ready register and keeps saturating statistics counters.
module branch_resolve #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_op,
   input  logic [4:0]        in_rt,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [15:0]       in_imm,
   input  logic              in_pred_taken,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_is_branch,
   output logic              out_taken,
   output logic              out_link_en,
   output logic              out_mispredict,
   output logic [DATA_W-1:0] out_target,
   output logic [DATA_W-1:0] out_link,
   output logic [DATA_W-1:0] out_redirect_pc,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  cnt_branch,
   output logic [CNT_W-1:0]  cnt_taken,
   output logic [CNT_W-1:0]  cnt_mispred
);

   logic              a_neg, a_zero;
   logic              is_branch_d, taken_d, link_en_d, mispredict_d;
   logic [DATA_W-1:0] imm_sx, offset, target_d, link_d, redirect_d;
   logic              accept, xfer;

   logic              out_valid_q;
   logic              is_branch_q, taken_q, link_en_q, mispredict_q;
   logic [DATA_W-1:0] target_q, link_q, redirect_q;
   logic [CNT_W-1:0]  cnt_branch_q, cnt_taken_q, cnt_mispred_q;

   assign a_neg  = in_a[DATA_W-1];
   assign a_zero = (in_a == '0);

   // Decode branch kind and outcome from opcode / REGIMM sub-op.
   always_comb begin
      is_branch_d = 1'b0;
      taken_d     = 1'b0;
      link_en_d   = 1'b0;
      case (in_op)
         6'b000100: begin is_branch_d = 1'b1; taken_d = (in_a == in_b); end
         6'b000101: begin is_branch_d = 1'b1; taken_d = (in_a != in_b); end
         6'b000110: begin is_branch_d = 1'b1; taken_d = a_neg | a_zero; end
         6'b000111: begin is_branch_d = 1'b1; taken_d = ~a_neg & ~a_zero; end
         6'b000001: begin
            case (in_rt)
               5'b00000, 5'b10000: begin
                  is_branch_d = 1'b1;
                  taken_d     = a_neg;
                  link_en_d   = in_rt[4];
               end
               5'b00001, 5'b10001: begin
                  is_branch_d = 1'b1;
                  taken_d     = ~a_neg;
                  link_en_d   = in_rt[4];
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // DATA_W >= 18 keeps the shifted 18-bit offset inside the datapath.
   assign imm_sx       = DATA_W'($signed(in_imm));
   assign offset       = {imm_sx[DATA_W-3:0], 2'b00};
   assign target_d     = in_pc + DATA_W'(4) + offset;
   assign link_d       = in_pc + DATA_W'(8);
   assign redirect_d   = taken_d ? target_d : link_d;
   assign mispredict_d = is_branch_d ? (taken_d != in_pred_taken) : in_pred_taken;

   assign in_ready = (~out_valid_q | out_ready) & ~flush;
   assign accept   = in_valid & in_ready;
   assign xfer     = out_valid_q & out_ready;

   // Result register: load on accept, drain on transfer, kill on flush.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         out_valid_q  <= 1'b0;
         is_branch_q  <= 1'b0;
         taken_q      <= 1'b0;
         link_en_q    <= 1'b0;
         mispredict_q <= 1'b0;
         target_q     <= '0;
         link_q       <= '0;
         redirect_q   <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_valid_q  <= 1'b1;
         is_branch_q  <= is_branch_d;
         taken_q      <= taken_d;
         link_en_q    <= link_en_d;
         mispredict_q <= mispredict_d;
         target_q     <= target_d;
         link_q       <= link_d;
         redirect_q   <= redirect_d;
      end else if (xfer) begin
         out_valid_q <= 1'b0;
      end
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
      return v;
   endfunction

   // Statistics: count on each output transfer (a flushed transfer still counts); clear wins.
   always_ff @(posedge clk) begin
      if (!resetn || cnt_clr) begin
         cnt_branch_q  <= '0;
         cnt_taken_q   <= '0;
         cnt_mispred_q <= '0;
      end else if (xfer) begin
         cnt_branch_q  <= sat_inc(cnt_branch_q, is_branch_q);
         cnt_taken_q   <= sat_inc(cnt_taken_q, taken_q);
         cnt_mispred_q <= sat_inc(cnt_mispred_q, mispredict_q);
      end
   end

   assign out_valid       = out_valid_q;
   assign out_is_branch   = is_branch_q;
   assign out_taken       = taken_q;
   assign out_link_en     = link_en_q;
   assign out_mispredict  = mispredict_q;
   assign out_target      = target_q;
   assign out_link        = link_q;
   assign out_redirect_pc = redirect_q;
   assign cnt_branch      = cnt_branch_q;
   assign cnt_taken       = cnt_taken_q;
   assign cnt_mispred     = cnt_mispred_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve (DATA_W=32, CNT_W=2 to reach saturation).
module tb_branch_resolve;

   logic        clk = 1'b0;
   logic        resetn, in_valid, in_ready, in_pred_taken, flush, out_valid, out_ready;
   logic [5:0]  in_op;
   logic [4:0]  in_rt;
   logic [31:0] in_a, in_b, in_pc;
   logic [15:0] in_imm;
   logic        out_is_branch, out_taken, out_link_en, out_mispredict, cnt_clr;
   logic [31:0] out_target, out_link, out_redirect_pc;
   logic [1:0]  cnt_branch, cnt_taken, cnt_mispred;

   typedef struct packed {
      logic        br, tk, le, mp;
      logic [31:0] tgt, lnk, rd;
   } res_t;

   res_t        sb_q[$];
   int unsigned m_br, m_tk, m_mp;
   int          n_checks = 0;
   int          n_errors = 0;

   branch_resolve #(.DATA_W(32), .CNT_W(2)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rt(in_rt), .in_a(in_a), .in_b(in_b), .in_pc(in_pc),
      .in_imm(in_imm), .in_pred_taken(in_pred_taken), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_is_branch(out_is_branch),
      .out_taken(out_taken), .out_link_en(out_link_en), .out_mispredict(out_mispredict),
      .out_target(out_target), .out_link(out_link), .out_redirect_pc(out_redirect_pc),
      .cnt_clr(cnt_clr), .cnt_branch(cnt_branch), .cnt_taken(cnt_taken),
      .cnt_mispred(cnt_mispred)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic res_t model(input logic [5:0] op, input logic [4:0] rt,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] pc, input logic [15:0] imm,
                                  input logic pred);
      res_t r;
      logic neg, z;
      neg = a[31];
      z   = (a == 32'd0);
      r   = '0;
      if (op == 6'd4)      begin r.br = 1'b1; r.tk = (a == b); end
      else if (op == 6'd5) begin r.br = 1'b1; r.tk = (a != b); end
      else if (op == 6'd6) begin r.br = 1'b1; r.tk = neg || z; end
      else if (op == 6'd7) begin r.br = 1'b1; r.tk = !neg && !z; end
      else if (op == 6'd1 && (rt == 5'd0 || rt == 5'd16)) begin
         r.br = 1'b1; r.tk = neg; r.le = (rt == 5'd16);
      end else if (op == 6'd1 && (rt == 5'd1 || rt == 5'd17)) begin
         r.br = 1'b1; r.tk = !neg; r.le = (rt == 5'd17);
      end
      r.tgt = pc + 32'd4 + ({{16{imm[15]}}, imm} << 2);
      r.lnk = pc + 32'd8;
      r.mp  = r.br ? (r.tk != pred) : pred;
      r.rd  = r.tk ? r.tgt : r.lnk;
      return r;
   endfunction

   function automatic int unsigned sat(input int unsigned c, input logic en);
      return (en && c < 3) ? c + 1 : c;
   endfunction

   // Monitor: compare against the model between edges, then advance the model.
   always @(negedge clk) begin
      res_t e;
      logic exp_ready, xfer;
      exp_ready = ((sb_q.size() == 0) || out_ready) && !flush;
      check("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("cnt_branch", 64'(cnt_branch), 64'(m_br));
      check("cnt_taken", 64'(cnt_taken), 64'(m_tk));
      check("cnt_mispred", 64'(cnt_mispred), 64'(m_mp));
      if (sb_q.size() != 0) begin
         e = sb_q[0];
         check("is_branch", 64'(out_is_branch), 64'(e.br));
         check("taken", 64'(out_taken), 64'(e.tk));
         check("link_en", 64'(out_link_en), 64'(e.le));
         check("mispredict", 64'(out_mispredict), 64'(e.mp));
         check("target", 64'(out_target), 64'(e.tgt));
         check("link", 64'(out_link), 64'(e.lnk));
         check("redirect", 64'(out_redirect_pc), 64'(e.rd));
      end
      xfer = (sb_q.size() != 0) && out_ready;
      if (!resetn) begin
         sb_q.delete();
         m_br = 0; m_tk = 0; m_mp = 0;
      end else begin
         if (xfer) begin
            e = sb_q.pop_front();
            if (!cnt_clr) begin
               m_br = sat(m_br, e.br);
               m_tk = sat(m_tk, e.tk);
               m_mp = sat(m_mp, e.mp);
            end
         end
         if (cnt_clr) begin m_br = 0; m_tk = 0; m_mp = 0; end
         if (flush) sb_q.delete();
         else if (in_valid && exp_ready)
            sb_q.push_back(model(in_op, in_rt, in_a, in_b, in_pc, in_imm, in_pred_taken));
      end
   end

   task automatic send(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [15:0] imm,
                       input logic pred);
      bit done;
      in_op = op; in_rt = rt; in_a = a; in_b = b; in_pc = pc; in_imm = imm;
      in_pred_taken = pred; in_valid = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
      end
      if (!done) check("send_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      m_br = 0; m_tk = 0; m_mp = 0;
      resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
      in_op = '0; in_rt = '0; in_a = '0; in_b = '0; in_pc = '0; in_imm = '0;
      in_pred_taken = 1'b0;
      cycles(3);
      resetn = 1'b1;
      cycles(1);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_flags", 64'({out_is_branch, out_taken, out_link_en, out_mispredict}), 64'd0);
      check("rst_target", 64'(out_target), 64'd0);
      check("rst_link", 64'(out_link), 64'd0);
      check("rst_redirect", 64'(out_redirect_pc), 64'd0);
      check("rst_cnts", 64'({cnt_branch, cnt_taken, cnt_mispred}), 64'd0);

      // BEQ taken with backwards offset, predicted not-taken.
      out_ready = 1'b0;
      send(6'b000100, 5'd0, 32'h1234, 32'h1234, 32'h0040_0000, 16'hFFFF, 1'b0);
      check("beq_valid", 64'(out_valid), 64'd1);
      check("beq_taken", 64'(out_taken), 64'd1);
      check("beq_target", 64'(out_target), 64'h0040_0000);
      check("beq_link", 64'(out_link), 64'h0040_0008);
      check("beq_mispred", 64'(out_mispredict), 64'd1);
      check("beq_redirect", 64'(out_redirect_pc), 64'h0040_0000);
      out_ready = 1'b1;
      cycles(1);

      // Sign/zero condition branches, back-to-back.
      send(6'b000110, 5'd0, 32'h0, 32'h0, 32'h100, 16'h0010, 1'b1);
      send(6'b000111, 5'd0, 32'h0, 32'h0, 32'h200, 16'h0020, 1'b1);
      send(6'b000001, 5'd16, 32'h8000_0000, 32'h0, 32'h300, 16'h8000, 1'b0);
      send(6'b000001, 5'd17, 32'h8000_0000, 32'h0, 32'h400, 16'h0001, 1'b0);
      cycles(1);

      // Address wrap.
      out_ready = 1'b0;
      send(6'b000101, 5'd0, 32'h1, 32'h2, 32'hFFFF_FFFC, 16'h0001, 1'b1);
      check("wrap_target", 64'(out_target), 64'h4);
      check("wrap_link", 64'(out_link), 64'h4);
      out_ready = 1'b1;
      cycles(1);

      // Non-branch encodings.
      send(6'b000000, 5'd0, 32'h5, 32'h5, 32'h500, 16'h0, 1'b1);
      send(6'b000001, 5'd2, 32'h8000_0000, 32'h0, 32'h600, 16'h0, 1'b0);
      cycles(2);

      // Backpressure: three requests against a stalled consumer.
      out_ready = 1'b0;
      fork
         begin
            send(6'b000100, 5'd0, 32'h7, 32'h7, 32'h1000, 16'h0004, 1'b1);
            send(6'b000101, 5'd0, 32'h7, 32'h7, 32'h2000, 16'h0008, 1'b1);
            send(6'b000110, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h3000, 16'hFFF0, 1'b0);
         end
         begin
            cycles(4);
            check("stall_ready", 64'(in_ready), 64'd0);
            out_ready = 1'b1;
         end
      join
      cycles(2);

      // Flush with held result and same-cycle request.
      out_ready = 1'b0;
      send(6'b000100, 5'd0, 32'h9, 32'h9, 32'h4000, 16'h0001, 1'b0);
      begin
         int unsigned saved_br;
         saved_br = m_br;
         in_valid = 1'b1; flush = 1'b1;
         in_op = 6'b000101; in_a = 32'h1; in_b = 32'h2;
         cycles(1);
         in_valid = 1'b0; flush = 1'b0;
         check("flush_valid", 64'(out_valid), 64'd0);
         check("flush_cnt", 64'(cnt_branch), 64'(saved_br));
      end
      out_ready = 1'b1;

      // Saturation with CNT_W=2, then clear racing a transfer.
      cnt_clr = 1'b1;
      cycles(1);
      cnt_clr = 1'b0;
      for (int i = 0; i < 4; i++)
         send(6'b000100, 5'd0, 32'hA, 32'hA, 32'h5000 + 32'(i * 4), 16'h0002, 1'b1);
      cycles(2);
      check("sat_taken", 64'(cnt_taken), 64'd3);
      check("sat_branch", 64'(cnt_branch), 64'd3);
      out_ready = 1'b0;
      send(6'b000100, 5'd0, 32'hB, 32'hB, 32'h6000, 16'h0002, 1'b0);
      cnt_clr = 1'b1; out_ready = 1'b1;
      cycles(1);
      cnt_clr = 1'b0;
      check("clr_cnts", 64'({cnt_branch, cnt_taken, cnt_mispred}), 64'd0);
      check("clr_valid", 64'(out_valid), 64'd0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic [5:0] ops [9];
         ops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd1, 6'd0, 6'd2, 6'd9};
         in_op = ops[$urandom_range(8)];
         case ($urandom_range(4))
            0: in_rt = 5'd0;
            1: in_rt = 5'd1;
            2: in_rt = 5'd16;
            3: in_rt = 5'd17;
            default: in_rt = 5'($urandom);
         endcase
         in_a = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
         in_b = ($urandom_range(2) == 0) ? in_a : $urandom;
         in_pc = $urandom & 32'hFFFF_FFFC;
         in_imm = 16'($urandom);
         in_pred_taken = 1'($urandom);
         in_valid = ($urandom_range(9) < 7);
         out_ready = ($urandom_range(9) < 7);
         flush = ($urandom_range(15) == 0);
         cnt_clr = ($urandom_range(31) == 0);
         cycles(1);
      end
      in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
      cycles(2);

      // Reset while a transfer is pending.
      out_ready = 1'b0;
      send(6'b000100, 5'd0, 32'hC, 32'hC, 32'h7000, 16'h0003, 1'b0);
      out_ready = 1'b1; resetn = 1'b0;
      cycles(1);
      resetn = 1'b1;
      check("rstx_valid", 64'(out_valid), 64'd0);
      check("rstx_cnts", 64'({cnt_branch, cnt_taken, cnt_mispred}), 64'd0);
      check("rstx_target", 64'(out_target), 64'd0);
      cycles(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand, PC and target width (>=18).
REQ-002 SHALL have parameter CNT_W, default 16: statistics counter width.
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 resetn  in  1  synchronous active-low reset.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  request accepted when in_valid & in_ready.
REQ-008 in_op  in  6  instruction opcode field.
REQ-009 in_rt  in  5  instruction rt field (REGIMM sub-op).
REQ-010 in_a, in_b  in  DATA_W  rs and rt operand values (forwarded).
REQ-011 in_pc  in  DATA_W  branch instruction PC.
REQ-012 in_imm  in  16  offset field.
REQ-013 in_pred_taken  in  1  front-end prediction for this instruction.
REQ-014 flush  in  1  kill the in-flight result and any same-cycle request.
REQ-015 out_valid  out  1  result register holds a valid result.
REQ-016 out_ready  in  1  consumer accepts; transfer on out_valid & out_ready.
REQ-017 out_is_branch, out_taken, out_link_en, out_mispredict  out  1 each  decoded flags.
REQ-018 out_target, out_link, out_redirect_pc  out  DATA_W  computed addresses.
REQ-019 cnt_clr  in  1  synchronous clear of all statistics counters.
REQ-020 cnt_branch, cnt_taken, cnt_mispred  out  CNT_W each  statistics counters.

Function
REQ-021 Conditions: BEQ(000100) a==b; BNE(000101) a!=b; BLEZ(000110) a[MSB]|(a==0); BGTZ(000111) !a[MSB]&(a!=0); REGIMM(000001) with rt BLTZ(00000)/BLTZAL(10000) a[MSB]; rt BGEZ(00001)/BGEZAL(10001) !a[MSB].
REQ-022 Any other op/rt combination SHALL give is_branch=0, taken=0, link_en=0.
REQ-023 link_en SHALL be 1 only for BLTZAL/BGEZAL, regardless of the branch outcome.
REQ-024 target SHALL be in_pc + 4 + (sign-extended in_imm << 2), modulo 2^DATA_W.
REQ-025 link SHALL be in_pc + 8, modulo 2^DATA_W.
REQ-026 mispredict SHALL be (taken != in_pred_taken) for branches and in_pred_taken for non-branches.
REQ-027 redirect_pc SHALL be target when taken, otherwise link.
REQ-028 The single result register SHALL give a latency of one cycle from input acceptance to out_valid.
REQ-029 in_ready SHALL be (!out_valid | out_ready) & !flush, combinationally.
REQ-030 With in_ready=1 held, SHALL sustain one accepted request per cycle.
REQ-031 On acceptance, the result register SHALL load and out_valid SHALL be 1 next cycle.
REQ-032 On an output transfer with no acceptance, out_valid SHALL be 0 next cycle.
REQ-033 While out_valid & !out_ready, all out_* SHALL hold stable.
REQ-034 flush=1 SHALL force out_valid=0 next cycle and drop any same-cycle input; a same-cycle output transfer still completes.
REQ-035 On each output transfer, counters SHALL update: cnt_branch += is_branch; cnt_taken += taken; cnt_mispred += mispredict.
REQ-036 Counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-037 cnt_clr SHALL zero the counters next cycle, taking priority over a same-cycle increment.

Reset
REQ-038 While resetn=0 at a clock edge: out_valid=0, all out_* flags and addresses=0, all counters=0.
REQ-039 During reset, in_ready SHALL read 1 only if flush=0, and any accepted input SHALL be discarded.
REQ-040 Reset mid-transfer SHALL discard the held result without a counter update.

Verification
REQ-041 BEQ, a=b=0x1234, pc=0x00400000, imm=0xFFFF, pred=0 -> next cycle out_taken=1, target=0x00400000, link=0x00400008, mispredict=1, redirect=0x00400000.
REQ-042 BLEZ a=0 -> taken=1; BGTZ a=0 -> taken=0; BLTZAL a=0x80000000 -> taken=1, link_en=1; BGEZAL a=0x80000000 -> taken=0, link_en=1.
REQ-043 Back-to-back requests with out_ready=0 for 3 cycles -> in_ready=0, outputs stable; then out_ready=1 -> one transfer per cycle, no loss.
REQ-044 Flush asserted with out_valid=1 and in_valid=1 -> out_valid=0 next cycle and no counter change.
REQ-045 CNT_W=2: four taken branch transfers -> cnt_taken=3 (saturated); cnt_clr with a simultaneous transfer -> all counters 0.
REQ-046 pc=0xFFFFFFFC, imm=0x0001 -> target=0x00000004, link=0x00000004 (wrap).
